// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator stage.
package sum_acc_pkg;

  localparam int unsigned DEF_IN_W  = 19;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_ACC_W = DEF_IN_W + DEF_CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accumulator_dff.sv
// Accumulates a programmed number of valid adder sums into a wide total and
// strobes the result for one cycle.
module sum_accumulator_dff
  import sum_acc_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned ACC_W = IN_W + CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             clr,
  input  logic [CNT_W-1:0] count_n,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             sum_vld,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_vld,
  output logic             busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_rem;
  logic [ACC_W-1:0]   r_acc_out;
  logic               r_acc_vld;
  logic               r_busy;
  logic               w_last;
  logic [ACC_W-1:0]   w_acc_sum;

  assign w_last    = (r_rem == CNT_W'(1));
  assign w_acc_sum = r_acc + ACC_W'(sum_in);

  // Next-state logic; clr overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (count_n == '0) ? DONE : ACCUM;
      ACCUM:   if (sum_vld && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (clr) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath: accumulator, remaining-count and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc     <= '0;
      r_rem     <= '0;
      r_acc_out <= '0;
      r_acc_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_acc_vld <= (w_state_nxt == DONE);
      r_busy    <= (w_state_nxt != IDLE);
      if (clr) begin
        r_acc     <= '0;
        r_rem     <= '0;
        r_acc_out <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_acc     <= '0;
              r_rem     <= count_n;
              r_acc_out <= '0;
            end
          end
          ACCUM: begin
            if (sum_vld) begin
              r_acc <= w_acc_sum;
              r_rem <= r_rem - CNT_W'(1);
              if (w_last) r_acc_out <= w_acc_sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign acc_out = r_acc_out;
  assign acc_vld = r_acc_vld;
  assign busy    = r_busy;

endmodule

// File: tb/tb_sum_accumulator_dff.sv
// Self-checking bench for sum_accumulator_dff: directed scenarios plus
// randomized runs checked against totals computed from the accepted samples.
module tb_sum_accumulator_dff;

  localparam int unsigned IN_W  = 19;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ACC_W = 27;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             clr;
  logic [CNT_W-1:0] count_n;
  logic [IN_W-1:0]  sum_in;
  logic             sum_vld;
  logic [ACC_W-1:0] acc_out;
  logic             acc_vld;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [IN_W-1:0] smp[$];

  sum_accumulator_dff dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .clr    (clr),
    .count_n(count_n),
    .sum_in (sum_in),
    .sum_vld(sum_vld),
    .acc_out(acc_out),
    .acc_vld(acc_vld),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run over the samples in smp; optional random gaps and a mid-run start pulse.
  task automatic run(input string tag, input int max_gap, input bit restart);
    longint exp_total = 0;
    int n = smp.size();
    start = 1'b1; count_n = CNT_W'(n); sum_vld = 1'b1; sum_in = IN_W'($urandom);
    tick();
    start = 1'b0; sum_vld = 1'b0;
    chk({tag, "_busy_start"}, 64'(busy), 64'(1));
    if (n == 0) begin
      chk({tag, "_vld_zero"}, 64'(acc_vld), 64'(1));
      chk({tag, "_out_zero"}, 64'(acc_out), 64'(0));
    end
    for (int i = 0; i < n; i++) begin
      int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        sum_vld = 1'b0; sum_in = IN_W'($urandom);
        tick();
        chk({tag, "_gap_novld"}, 64'(acc_vld), 64'(0));
      end
      if (restart && i == 0) begin
        start = 1'b1; count_n = CNT_W'(9);
      end
      sum_vld = 1'b1; sum_in = smp[i];
      exp_total += longint'(smp[i]);
      tick();
      start = 1'b0;
      if (i < n - 1) begin
        chk({tag, "_mid_vld"}, 64'(acc_vld), 64'(0));
        chk({tag, "_mid_busy"}, 64'(busy), 64'(1));
      end else begin
        chk({tag, "_done_vld"}, 64'(acc_vld), 64'(1));
        chk({tag, "_done_out"}, 64'(acc_out), 64'(exp_total));
      end
    end
    // sum_vld during DONE must be ignored
    sum_vld = 1'b1; sum_in = IN_W'($urandom);
    tick();
    sum_vld = 1'b0;
    chk({tag, "_idle_vld"}, 64'(acc_vld), 64'(0));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    chk({tag, "_held_out"}, 64'(acc_out), 64'(exp_total));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; clr = 1'b0; count_n = '0; sum_in = '0; sum_vld = 1'b0;
    tick(); tick();
    chk("rst_out", 64'(acc_out), 64'(0));
    chk("rst_vld", 64'(acc_vld), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    tick();

    // Basic run 1+2+3+4
    smp = '{19'd1, 19'd2, 19'd3, 19'd4};
    run("basic", 0, 1'b0);

    // Max values with gaps
    smp = '{19'h7FFFF, 19'h7FFFF, 19'h7FFFF};
    run("maxgap", 3, 1'b0);

    // Zero count then start re-pulsed mid-run
    smp.delete();
    run("zero", 0, 1'b0);
    smp = '{19'd100, 19'd200};
    run("restart", 2, 1'b1);

    // Abort with clr+start after 2 of 5 samples
    start = 1'b1; count_n = 8'd5; tick(); start = 1'b0;
    sum_vld = 1'b1; sum_in = 19'd11; tick();
    sum_in = 19'd12; tick();
    sum_vld = 1'b0; clr = 1'b1; start = 1'b1; count_n = 8'd3;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_vld", 64'(acc_vld), 64'(0));
    chk("abort_out", 64'(acc_out), 64'(0));
    sum_vld = 1'b1; sum_in = 19'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_idle_vld", 64'(acc_vld), 64'(0));
    end
    sum_vld = 1'b0;
    smp = '{19'd7};
    run("post_abort", 0, 1'b0);

    // Reset mid-run after 3 of 5 samples, asserted between edges
    start = 1'b1; count_n = 8'd5; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum_vld = 1'b1; sum_in = 19'd1000; tick();
    end
    sum_vld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_out", 64'(acc_out), 64'(0));
    chk("midrst_vld", 64'(acc_vld), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sum_vld = 1'(k % 2 == 0); sum_in = 19'd3; tick();
      chk("midrst_novld", 64'(acc_vld), 64'(0));
      chk("midrst_nobusy", 64'(busy), 64'(0));
    end
    sum_vld = 1'b0;

    // Start held through DONE is taken at the first IDLE edge
    smp = '{19'd9};
    start = 1'b1; count_n = 8'd1; tick();
    sum_vld = 1'b1; sum_in = 19'd9; count_n = 8'd2; tick();
    sum_vld = 1'b0;
    chk("held_done_vld", 64'(acc_vld), 64'(1));
    chk("held_done_out", 64'(acc_out), 64'(9));
    tick();
    chk("held_idle_busy", 64'(busy), 64'(0));
    tick();
    start = 1'b0;
    chk("held_restart_busy", 64'(busy), 64'(1));
    chk("held_restart_out", 64'(acc_out), 64'(0));
    sum_vld = 1'b1; sum_in = 19'd20; tick();
    sum_in = 19'd22; tick();
    sum_vld = 1'b0;
    chk("held_run_vld", 64'(acc_vld), 64'(1));
    chk("held_run_out", 64'(acc_out), 64'(42));
    tick();

    // Longest run, all maximum samples
    smp.delete();
    for (int i = 0; i < 255; i++) smp.push_back(19'h7FFFF);
    run("longest", 0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int n = int'($urandom_range(12, 0));
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(IN_W'($urandom));
      run("rand", 2, 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
